// File: rtl/utf8_pkg.sv
// Shared UTF-8 definitions: status encoding common to encoder and decoder,
// code-point limits, byte prefixes and the encoder's packed sequence type.
package utf8_pkg;

  typedef enum logic [1:0] {
    STATUS_INITIAL   = 2'd0,
    STATUS_INPROCESS = 2'd1,
    STATUS_READY     = 2'd2,
    STATUS_ERROR     = 2'd3
  } status_e;

  localparam logic [20:0] MAX_CODE_POINT = 21'h10FFFF;
  localparam logic [20:0] SURROGATE_LO   = 21'h00D800;
  localparam logic [20:0] SURROGATE_HI   = 21'h00DFFF;
  localparam logic [20:0] REPLACEMENT    = 21'h00FFFD;

  localparam logic [20:0] MAX_1BYTE = 21'h00007F;
  localparam logic [20:0] MAX_2BYTE = 21'h0007FF;
  localparam logic [20:0] MAX_3BYTE = 21'h00FFFF;

  localparam logic       LEAD1_PREFIX = 1'b0;
  localparam logic [2:0] LEAD2_PREFIX = 3'b110;
  localparam logic [3:0] LEAD3_PREFIX = 4'b1110;
  localparam logic [4:0] LEAD4_PREFIX = 5'b11110;
  localparam logic [1:0] CONT_PREFIX  = 2'b10;

  // First byte to transmit sits in bytes[31:24]; last_idx is length-1.
  typedef struct packed {
    logic        valid;
    logic [1:0]  last_idx;
    logic [31:0] bytes;
  } packed_seq_t;

  function automatic logic is_scalar_value(input logic [20:0] cp);
    return (cp <= MAX_CODE_POINT) && !((cp >= SURROGATE_LO) && (cp <= SURROGATE_HI));
  endfunction

  function automatic logic [7:0] cont_byte(input logic [5:0] bits);
    return {CONT_PREFIX, bits};
  endfunction

endpackage

// File: rtl/utf8_encode_packer.sv
// Combinational code point -> UTF-8 byte vector, length and validity.
module utf8_encode_packer
  import utf8_pkg::*;
(
  input  logic [20:0]  i_code_point,
  output packed_seq_t  o_seq
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_seq = '0;
    if (is_scalar_value(i_code_point)) begin
      o_seq.valid = 1'b1;
      if (i_code_point <= MAX_1BYTE) begin
        o_seq.last_idx = 2'd0;
        o_seq.bytes    = {LEAD1_PREFIX, i_code_point[6:0], 24'h000000};
      end else if (i_code_point <= MAX_2BYTE) begin
        o_seq.last_idx = 2'd1;
        o_seq.bytes    = {LEAD2_PREFIX, i_code_point[10:6],
                          cont_byte(i_code_point[5:0]), 16'h0000};
      end else if (i_code_point <= MAX_3BYTE) begin
        o_seq.last_idx = 2'd2;
        o_seq.bytes    = {LEAD3_PREFIX, i_code_point[15:12],
                          cont_byte(i_code_point[11:6]),
                          cont_byte(i_code_point[5:0]), 8'h00};
      end else begin
        o_seq.last_idx = 2'd3;
        o_seq.bytes    = {LEAD4_PREFIX, i_code_point[20:18],
                          cont_byte(i_code_point[17:12]),
                          cont_byte(i_code_point[11:6]),
                          cont_byte(i_code_point[5:0])};
      end
    end
  end

endmodule

// File: rtl/utf8_encoder.sv
// Streaming UTF-8 encoder: one code point in, 1-4 bytes out via valid/ready.
// Optional UTF8_ENCODER_REPLACE_EN: invalid code points emit U+FFFD instead of being dropped.
module utf8_encoder
  import utf8_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [20:0] in_code_point,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        error,
  output logic [1:0]  status
);

  typedef enum logic {ST_IDLE, ST_EMIT} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_shift;
  logic [1:0]  r_count;
  status_e     r_status;
  logic        r_error;

  logic        w_cp_ok;
  logic [20:0] w_pack_cp;
  packed_seq_t w_seq;
  logic        w_accept;
  logic        w_load;
  logic        w_out_fire;
  logic        w_last_fire;

  assign w_cp_ok = is_scalar_value(in_code_point);

`ifdef UTF8_ENCODER_REPLACE_EN
  assign w_pack_cp = w_cp_ok ? in_code_point : REPLACEMENT;
`else
  assign w_pack_cp = in_code_point;
`endif

  utf8_encode_packer u_packer (
    .i_code_point (w_pack_cp),
    .o_seq        (w_seq)
  );

  assign w_accept    = in_valid && in_ready;
  assign w_load      = w_accept && w_seq.valid;
  assign w_out_fire  = out_valid && out_ready;
  assign w_last_fire = w_out_fire && out_last;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: a load wins over the final handshake so back-to-back
  // code points stream without a bubble.
  always_comb begin
    w_state_next = r_state;
    if (w_load)           w_state_next = ST_EMIT;
    else if (w_last_fire) w_state_next = ST_IDLE;
  end

  // Output logic; in_ready deliberately depends combinationally on out_ready.
  always_comb begin
    out_valid = (r_state == ST_EMIT);
    out_last  = out_valid && (r_count == 2'd0);
    in_ready  = (r_state == ST_IDLE) || (out_valid && out_last && out_ready);
  end

  // Byte shift register and remaining-byte count.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: the shift register is reset because out_byte must read 0x00 in reset.
    if (reset) begin
      r_shift <= '0;
      r_count <= 2'd0;
    end else if (w_load) begin
      r_shift <= w_seq.bytes;
      r_count <= w_seq.last_idx;
    end else if (w_out_fire) begin
      r_shift <= {r_shift[23:0], 8'h00};
      if (r_count != 2'd0) r_count <= r_count - 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_status <= STATUS_INITIAL;
      r_error  <= 1'b0;
    end else begin
      r_error <= w_accept && !w_cp_ok;
      if (w_accept)         r_status <= w_seq.valid ? STATUS_INPROCESS : STATUS_ERROR;
      else if (w_last_fire) r_status <= STATUS_READY;
    end
  end

  assign out_byte = r_shift[31:24];
  assign error    = r_error;
  assign status   = r_status;

endmodule

// File: tb/tb_utf8_encoder.sv
// Directed self-checking bench for utf8_encoder; a negedge monitor compares
// every output handshake against a queue of hand-computed bytes.
`timescale 1ns/1ps
module tb_utf8_encoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_code_point;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        error;
  logic [1:0]  status;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q [$];

  utf8_encoder dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_code_point (in_code_point),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_byte      (out_byte),
    .out_last      (out_last),
    .error         (error),
    .status        (status)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Each handshake is seen here half a cycle before the edge that commits it.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {23'h0, out_last, out_byte}, 32'h0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("out_byte_last", {23'h0, out_last, out_byte}, {23'h0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_seq(input logic [31:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = bytes[31-8*i -: 8];
      exp_q.push_back({(i == n - 1), b});
    end
  endtask

  task automatic send(input logic [20:0] cp, output int waited);
    waited = 0;
    in_valid      = 1'b1;
    in_code_point = cp;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (out_valid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'd0, 32'd1);
  endtask

  logic [20:0] bnd_cp    [7] = '{21'h7F, 21'h80, 21'h7FF, 21'h800, 21'hFFFF, 21'h10000, 21'h10FFFF};
  logic [31:0] bnd_bytes [7] = '{32'h7F000000, 32'hC2800000, 32'hDFBF0000, 32'hE0A08000,
                                 32'hEFBFBF00, 32'hF0908080, 32'hF48FBFBF};
  int          bnd_n     [7] = '{1, 2, 2, 3, 3, 4, 4};
  logic [20:0] bad_cp    [3] = '{21'h00D800, 21'h00DFFF, 21'h110000};

  initial begin
    int w;
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_code_point = '0;
    out_ready     = 1'b1;
    #2;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte",  out_byte,  8'h00);
    check("rst_out_last",  out_last,  0);
    check("rst_error",     error,     0);
    check("rst_status",    status,    2'd0);
    tick();
    reset = 1'b0;

    // 0x41 then 0x20AC streamed with no bubble.
    expect_seq(32'h41000000, 1);
    expect_seq(32'hE282AC00, 3);
    send(21'h41, w);
    check("a_byte",        out_byte, 8'h41);
    check("a_in_ready",    in_ready, 1);
    send(21'h20AC, w);
    check("euro_no_wait",  w, 0);
    check("euro_b0",       {out_valid, out_byte}, {1'b1, 8'hE2});
    check("euro_status",   status, 2'd1);
    tick();
    check("euro_b1",       out_byte, 8'h82);
    check("euro_b1_ready", in_ready, 0);
    tick();
    check("euro_b2",       {out_last, out_byte}, {1'b1, 8'hAC});
    check("euro_b2_ready", in_ready, 1);
    tick();
    check("euro_idle",     out_valid, 0);
    check("euro_status_end", status, 2'd2);

    // Boundary code points, back to back.
    for (int i = 0; i < 7; i++) expect_seq(bnd_bytes[i], bnd_n[i]);
    for (int i = 0; i < 7; i++) send(bnd_cp[i], w);
    wait_idle();
    check("bnd_drained", exp_q.size(), 0);

    // 0x1F600 with a 3-cycle stall on 9F.
    expect_seq(32'hF09F9880, 4);
    send(21'h1F600, w);
    check("emoji_b0", out_byte, 8'hF0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_byte",  {out_valid, out_last, out_byte}, {1'b1, 1'b0, 8'h9F});
      check("stall_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    check("stall_release", out_byte, 8'h9F);
    tick();
    check("emoji_b2_ready", in_ready, 0);
    tick();
    check("emoji_b3_ready", in_ready, 1);
    wait_idle();
    check("emoji_status", status, 2'd2);

    // Invalid code points.
    for (int i = 0; i < 3; i++) begin
`ifdef UTF8_ENCODER_REPLACE_EN
      expect_seq(32'hEFBFBD00, 3);
`endif
      send(bad_cp[i], w);
      check("bad_error_pulse", error, 1);
`ifdef UTF8_ENCODER_REPLACE_EN
      check("bad_repl_valid",  out_valid, 1);
      check("bad_repl_status", status, 2'd1);
      tick();
      check("bad_error_once",  error, 0);
      wait_idle();
      check("bad_repl_done",   status, 2'd2);
`else
      check("bad_no_valid",    out_valid, 0);
      check("bad_status",      status, 2'd3);
      tick();
      check("bad_error_once",  error, 0);
      check("bad_still_idle",  out_valid, 0);
`endif
    end
    check("bad_drained", exp_q.size(), 0);

    // Reset in the middle of 0xE9: C3 consumed, A9 discarded.
    exp_q.push_back({1'b0, 8'hC3});
    send(21'hE9, w);
    check("e9_b0", out_byte, 8'hC3);
    tick();
    check("e9_b1_pending", out_byte, 8'hA9);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_byte",  out_byte,  8'h00);
    check("mid_rst_out_last",  out_last,  0);
    check("mid_rst_in_ready",  in_ready,  1);
    check("mid_rst_status",    status,    2'd0);
    check("mid_rst_error",     error,     0);
    tick();
    reset = 1'b0;
    expect_seq(32'h41000000, 1);
    send(21'h41, w);
    check("post_rst_byte", {out_last, out_byte}, {1'b1, 8'h41});
    wait_idle();
    tick();
    check("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/utf8_encoder.md
# utf8_encoder

Streaming UTF-8 encoder. It accepts one Unicode scalar value per handshake and emits its 1–4 byte UTF-8 sequence, one byte per output handshake. It is the transmit-side counterpart of the byte-wise UTF-8 decoder and shares that decoder's status encoding, so both can sit on the same text path. Surrogates (U+D800–U+DFFF) and values above U+10FFFF are rejected.

## Interface
Parameters: none. All widths are fixed by the UTF-8 protocol.

- clock  input  1  — single clock; all flops rise on posedge.
- reset  input  1  — asynchronous, active-high; clears all state immediately.
- in_valid  input  1  — in_code_point is valid.
- in_ready  output  1  — encoder accepts a code point this cycle.
- in_code_point  input  21  — scalar value to encode.
- out_valid  output  1  — out_byte is valid.
- out_ready  input  1  — downstream consumes out_byte this cycle.
- out_byte  output  8  — current encoded byte.
- out_last  output  1  — out_byte is the final byte of its sequence.
- error  output  1  — one-cycle pulse: the accepted code point was invalid.
- status  output  2  — 0 INITIAL, 1 INPROCESS, 2 READY, 3 ERROR (same as the decoder).

## Operation
- States:
  - IDLE: out_valid=0.
  - EMIT: out_valid=1; a byte shift register holds 4×8 bits and a 2-bit remaining count holds bytes−1.
- Accept condition: in_valid && in_ready.
  - in_ready = (state==IDLE) | (out_valid & out_last & out_ready).
  - This is a combinational path from out_ready to in_ready, by design.
- Length classification:
  - ≤0x7F → 1 byte.
  - ≤0x7FF → 2 bytes.
  - ≤0xFFFF → 3 bytes.
  - ≤0x10FFFF → 4 bytes.
  - 0xD800–0xDFFF or >0x10FFFF → invalid.
- Byte construction:
  - Lead byte = {0xxxxxxx | 110xxxxx | 1110xxxx | 11110xxx} carrying the top bits.
  - Continuation bytes = 0x80 | 6-bit slice, most significant first.
- Valid accept:
  - Load the sequence, go to EMIT, status←1.
  - Each out handshake shifts to the next byte.
  - The handshake on the out_last byte sets status←2 and goes to IDLE, unless a new accept occurs in the same cycle; then EMIT reloads.
- Invalid accept:
  - The code point is consumed and no bytes are emitted.
  - error=1 for exactly one cycle, status←3, state stays IDLE.
- out_byte and out_last are stable while out_valid && !out_ready.
- Bits 20:0 are compared unsigned. There are no other input constraints.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_byte=0x00, out_last=0, error=0, status=0.
  - state IDLE, count 0.
- Latency: first byte is valid on the cycle after accept. Error pulses on the cycle after accept.
- Throughput: with out_ready held at 1, an N-byte code point takes N cycles, and back-to-back code points have no bubble.
- Status is held until the next event.
- Reset mid-sequence: remaining bytes are discarded and outputs go to reset values asynchronously. No partial sequence is resumed.
- in_valid while busy and not on the last handshake: no accept, and the input must be held by the source.

## Configuration
- UTF8_ENCODER_REPLACE_EN defined:
  - An invalid code point is encoded as U+FFFD (EF BF BD), following the normal EMIT timing.
  - error still pulses one cycle after accept.
  - status goes to 1, then to 2 after the BD byte, never 3.
- Macro undefined: reject behaviour as described under Operation.

## Structure
- Shared package utf8_pkg holds:
  - Status constants STATUS_INITIAL/INPROCESS/READY/ERROR (shared with the decoder).
  - Limits: MAX_CODE_POINT=0x10FFFF, SURROGATE_LO=0xD800, SURROGATE_HI=0xDFFF, REPLACEMENT=0xFFFD.
  - Prefix constants for the lead and continuation bytes.
- One combinational sub-module, utf8_encode_packer: code point → {valid, length, 32-bit byte vector}. The top level holds only the handshake FSM and the shift register.

## Test plan
- Send 0x41 then 0x20AC with out_ready=1.
  - Expect 41(last), E2, 82, AC(last) on consecutive cycles.
  - in_ready is high on the last-byte cycles; status ends at 2.
- Boundary values; each must produce exactly the listed sequence with out_last only on the final byte:
  - 0x7F → 7F
  - 0x80 → C2 80
  - 0x7FF → DF BF
  - 0x800 → E0 A0 80
  - 0xFFFF → EF BF BF
  - 0x10000 → F0 90 80 80
  - 0x10FFFF → F4 8F BF BF
- Send 0x1F600 with out_ready low for 3 cycles on byte 9F.
  - Output is F0 9F 98 80; 9F is held stable throughout the stall; no in_ready until the final handshake.
- Send 0xD800, 0xDFFF, 0x110000.
  - Without the macro: no out_valid, error pulses once per value, status=3.
  - With UTF8_ENCODER_REPLACE_EN: EF BF BD per value, with the error pulse.
- Accept 0xE9 (C3 A9), then assert reset after C3 is consumed.
  - All outputs return to reset values in the same cycle; A9 is never emitted.
  - The next code point 0x41 produces only 41.
